// File: rtl/pcs_pkg.sv
// pcs_pkg: shared types and defaults for the 40G PCS TX slot scheduler.
//   AM_PERIOD_DEF : data blocks per lane between alignment markers
//   GB_PERIOD_DEF : gearbox cycle length in clocks (last clock is a stall)
//   slot_e        : what the 4-lane block slot carries this cycle
//   state_e       : scheduler FSM state
package pcs_pkg;

    localparam int unsigned AM_PERIOD_DEF = 16383;
    localparam int unsigned GB_PERIOD_DEF = 33;

    typedef enum logic [1:0] {
        SLOT_DATA,
        SLOT_AM,
        SLOT_STALL
    } slot_e;

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

endpackage

// File: rtl/pcs_40g_tx_flow_ctrl_if.sv
// pcs_40g_tx_flow_ctrl_if: control bundle between link management, the slot
// scheduler and the pcs_40g_tx datapath.
//   tx_en_i    : transmit enable into the scheduler
//   ready_o    : MAC block accepted this cycle
//   am_v_o     : per-lane AM insert (all bits equal)
//   gb_stall_o : gearbox stall, no block enters the datapath
//   gb_seq_o   : gearbox phase for the datapath shift mux
//   am_cnt_o   : data blocks since the last AM (debug)
// master = scheduler side, slave = consumer/driver side.
interface pcs_40g_tx_flow_ctrl_if
    import pcs_pkg::*;
#(
    parameter int unsigned LANE_N    = 4,
    parameter int unsigned AM_PERIOD = AM_PERIOD_DEF,
    parameter int unsigned GB_PERIOD = GB_PERIOD_DEF
);
    localparam int unsigned GB_W = $clog2(GB_PERIOD);
    localparam int unsigned AM_W = $clog2(AM_PERIOD + 1);

    logic              tx_en_i;
    logic              ready_o;
    logic [LANE_N-1:0] am_v_o;
    logic              gb_stall_o;
    logic [GB_W-1:0]   gb_seq_o;
    logic [AM_W-1:0]   am_cnt_o;

    modport master (
        input  tx_en_i,
        output ready_o,
        output am_v_o,
        output gb_stall_o,
        output gb_seq_o,
        output am_cnt_o
    );

    modport slave (
        output tx_en_i,
        input  ready_o,
        input  am_v_o,
        input  gb_stall_o,
        input  gb_seq_o,
        input  am_cnt_o
    );

endinterface

// File: rtl/pcs_wrap_cnt.sv
// pcs_wrap_cnt: modulo-N up counter with enable and synchronous clear.
//   clk, nreset : clock, synchronous active-low reset
//   i_en        : count this cycle
//   i_clr       : clear to 0 (wins over i_en)
//   o_cnt       : current count, 0 .. N-1
//   o_last      : o_cnt == N-1
module pcs_wrap_cnt #(
    parameter int unsigned N = 33,
    parameter int unsigned W = $clog2(N)
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         i_en,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt,
    output logic         o_last
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!nreset || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_last = (r_cnt == LAST);

endmodule

// File: rtl/pcs_40g_tx_flow_ctrl.sv
// pcs_40g_tx_flow_ctrl: per-cycle slot scheduler for the 40G PCS TX path.
// Each RUN cycle the shared 4-lane slot is a gearbox STALL, an alignment
// marker (AM) or MAC DATA, in that priority. Outputs are a Moore decode of
// the registered state (no output register stage).
//   clk, nreset : clock, synchronous active-low reset
//   io_bus      : master side of pcs_40g_tx_flow_ctrl_if
module pcs_40g_tx_flow_ctrl
    import pcs_pkg::*;
#(
    parameter int unsigned LANE_N    = 4,
    parameter int unsigned AM_PERIOD = AM_PERIOD_DEF,
    parameter int unsigned GB_PERIOD = GB_PERIOD_DEF
) (
    input  logic                  clk,
    input  logic                  nreset,
    pcs_40g_tx_flow_ctrl_if.master io_bus
);

    localparam int unsigned GB_W = $clog2(GB_PERIOD);
    localparam int unsigned AM_W = $clog2(AM_PERIOD + 1);
    localparam logic [AM_W-1:0] AM_LAST = AM_W'(AM_PERIOD);

    if (AM_PERIOD < 2 || GB_PERIOD < 2) begin : g_param_err
        $error("pcs_40g_tx_flow_ctrl: AM_PERIOD and GB_PERIOD must be >= 2");
    end

    state_e          r_state;
    logic [AM_W-1:0] r_am_cnt;
    logic            r_am_pend;

    logic            w_run;
    logic            w_leave;
    logic [GB_W-1:0] w_gb_cnt;
    logic            w_gb_last;
    logic [AM_W-1:0] w_am_inc;
    slot_e           w_slot;

    assign w_run    = (r_state == RUN);
    assign w_leave  = w_run && !io_bus.tx_en_i;
    assign w_am_inc = r_am_cnt + 1'b1;

    // Gearbox phase: advances on every RUN cycle, cleared when leaving RUN.
    pcs_wrap_cnt #(
        .N (GB_PERIOD),
        .W (GB_W)
    ) u_gb_cnt (
        .clk    (clk),
        .nreset (nreset),
        .i_en   (w_run),
        .i_clr  (w_leave),
        .o_cnt  (w_gb_cnt),
        .o_last (w_gb_last)
    );

    // A pending AM waits out a stall; no DATA is granted while it is pending.
    always_comb begin
        w_slot = SLOT_DATA;
        if (w_gb_last) begin
            w_slot = SLOT_STALL;
        end else if (r_am_pend) begin
            w_slot = SLOT_AM;
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_state   <= IDLE;
            r_am_cnt  <= '0;
            r_am_pend <= 1'b1;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (io_bus.tx_en_i) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (!io_bus.tx_en_i) begin
                        // Re-entry always starts with an AM to realign lanes.
                        r_state   <= IDLE;
                        r_am_cnt  <= '0;
                        r_am_pend <= 1'b1;
                    end else begin
                        unique case (w_slot)
                            SLOT_DATA: begin
                                r_am_cnt <= w_am_inc;
                                if (w_am_inc == AM_LAST) begin
                                    r_am_pend <= 1'b1;
                                end
                            end
                            SLOT_AM: begin
                                r_am_cnt  <= '0;
                                r_am_pend <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        io_bus.ready_o    = 1'b0;
        io_bus.am_v_o     = '0;
        io_bus.gb_stall_o = 1'b0;
        if (w_run) begin
            unique case (w_slot)
                SLOT_DATA:  io_bus.ready_o    = 1'b1;
                SLOT_AM:    io_bus.am_v_o     = {LANE_N{1'b1}};
                SLOT_STALL: io_bus.gb_stall_o = 1'b1;
                default: ;
            endcase
        end
    end

    assign io_bus.gb_seq_o = w_gb_cnt;
    assign io_bus.am_cnt_o = r_am_cnt;

    a_onehot_run : assert property (@(posedge clk) disable iff (!nreset)
        w_run |-> $onehot({io_bus.ready_o, |io_bus.am_v_o, io_bus.gb_stall_o}));

    a_quiet_idle : assert property (@(posedge clk) disable iff (!nreset)
        !w_run |-> !(io_bus.ready_o || (|io_bus.am_v_o) || io_bus.gb_stall_o));

    a_am_cnt_max : assert property (@(posedge clk) disable iff (!nreset)
        r_am_cnt <= AM_LAST);

endmodule

// File: tb/tb_pcs_40g_tx_flow_ctrl.sv
// tb_pcs_40g_tx_flow_ctrl: three scheduler instances (default, 5/7, 4/8)
// checked every cycle against an episode-level model, plus pinned literals.
// Model view: in a RUN episode, clock k has gearbox phase k % GB; the non-stall
// slots form the repeating sequence AM, DATA x AM_PERIOD, AM, ...
module tb_pcs_40g_tx_flow_ctrl;

    logic       clk;
    logic [2:0] nrst;
    logic [2:0] tx_en;
    bit         chk_en;

    int unsigned vectors;
    int unsigned miscompares;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input int inst,
                                  input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s (inst %0d @%0t): got %0h expected %0h", name, inst, $time, act,
                     exp);
        end
    endfunction

    for (genvar gi = 0; gi < 3; gi++) begin : g_inst
        localparam int unsigned P = (gi == 0) ? 16383 : (gi == 1) ? 5 : 4;
        localparam int unsigned G = (gi == 0) ? 33 : (gi == 1) ? 7 : 8;

        pcs_40g_tx_flow_ctrl_if #(
            .LANE_N    (4),
            .AM_PERIOD (P),
            .GB_PERIOD (G)
        ) bus ();

        assign bus.tx_en_i = tx_en[gi];

        pcs_40g_tx_flow_ctrl #(
            .LANE_N    (4),
            .AM_PERIOD (P),
            .GB_PERIOD (G)
        ) u_dut (
            .clk    (clk),
            .nreset (nrst[gi]),
            .io_bus (bus)
        );

        // Episode model: m_k = RUN clocks elapsed, m_j = non-stall slots elapsed.
        bit          m_run;
        int unsigned m_k;
        int unsigned m_j;

        always @(posedge clk) begin
            if (!nrst[gi]) begin
                m_run <= 1'b0;
                m_k   <= 0;
                m_j   <= 0;
            end else if (m_run) begin
                if (!tx_en[gi]) begin
                    m_run <= 1'b0;
                    m_k   <= 0;
                    m_j   <= 0;
                end else begin
                    m_k <= m_k + 1;
                    if ((m_k % G) != G - 1) m_j <= m_j + 1;
                end
            end else if (tx_en[gi]) begin
                m_run <= 1'b1;
            end
        end

        int unsigned since;
        bit          seen;

        always @(negedge clk) begin
            int unsigned r, ecnt, eseq;
            logic erdy, eam, est;
            if (chk_en) begin
                erdy = 1'b0;
                eam  = 1'b0;
                est  = 1'b0;
                eseq = 0;
                ecnt = 0;
                r    = 0;
                if (m_run) begin
                    eseq = m_k % G;
                    r    = m_j % (P + 1);
                    ecnt = (r == 0) ? ((m_j == 0) ? 0 : P) : r - 1;
                    if (eseq == G - 1) est = 1'b1;
                    else if (r == 0) eam = 1'b1;
                    else erdy = 1'b1;
                end
                check("ready_o", gi, bus.ready_o, erdy);
                check("am_v_o", gi, bus.am_v_o, eam ? 32'hF : 32'h0);
                check("gb_stall_o", gi, bus.gb_stall_o, est);
                check("gb_seq_o", gi, bus.gb_seq_o, eseq);
                check("am_cnt_o", gi, bus.am_cnt_o, ecnt);

                // DUT-observed spacing: AM_PERIOD ready cycles between AM pulses.
                if (!m_run) begin
                    seen  <= 1'b0;
                    since <= 0;
                end else if (bus.am_v_o[0]) begin
                    if (seen) check("am_interval", gi, since, P);
                    seen  <= 1'b1;
                    since <= 0;
                end else if (bus.ready_o) begin
                    since <= since + 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        nrst   = '0;
        tx_en  = '0;
        chk_en = 1'b0;
        vectors     = 0;
        miscompares = 0;
        repeat (3) tick();
        chk_en = 1'b1;
        nrst   = '1;
        tick();
        check("rst ready", 0, g_inst[0].bus.ready_o, 0);
        check("rst am_v", 0, g_inst[0].bus.am_v_o, 0);
        check("rst gb_seq", 0, g_inst[0].bus.gb_seq_o, 0);

        // Default instance: first RUN slot is AM, then DATA with am_cnt 0.
        tx_en[0] = 1'b1;
        tick();
        check("lit c1 am_v", 0, g_inst[0].bus.am_v_o, 4'hF);
        check("lit c1 ready", 0, g_inst[0].bus.ready_o, 0);
        check("lit c1 gb_seq", 0, g_inst[0].bus.gb_seq_o, 0);
        tick();
        check("lit c2 ready", 0, g_inst[0].bus.ready_o, 1);
        check("lit c2 am_cnt", 0, g_inst[0].bus.am_cnt_o, 0);

        // AM_PERIOD=5, GB_PERIOD=7: AM deferred past the stall at k6.
        tx_en[1] = 1'b1;
        tick();
        check("lit k0 am_v", 1, g_inst[1].bus.am_v_o, 4'hF);
        check("lit k0 gb_seq", 1, g_inst[1].bus.gb_seq_o, 0);
        tick();
        check("lit k1 ready", 1, g_inst[1].bus.ready_o, 1);
        repeat (5) tick();
        check("lit k6 stall", 1, g_inst[1].bus.gb_stall_o, 1);
        check("lit k6 gb_seq", 1, g_inst[1].bus.gb_seq_o, 6);
        check("lit k6 am_cnt", 1, g_inst[1].bus.am_cnt_o, 5);
        tick();
        check("lit k7 am_v", 1, g_inst[1].bus.am_v_o, 4'hF);
        check("lit k7 gb_seq", 1, g_inst[1].bus.gb_seq_o, 0);
        tick();
        check("lit k8 ready", 1, g_inst[1].bus.ready_o, 1);
        check("lit k8 am_cnt", 1, g_inst[1].bus.am_cnt_o, 0);
        repeat (4) tick();
        // Reset pulse at k12 with tx_en held high.
        nrst[1] = 1'b0;
        tick();
        check("lit rst ready", 1, g_inst[1].bus.ready_o, 0);
        check("lit rst am_v", 1, g_inst[1].bus.am_v_o, 0);
        check("lit rst am_cnt", 1, g_inst[1].bus.am_cnt_o, 0);
        nrst[1] = 1'b1;
        tick();
        check("lit reent am_v", 1, g_inst[1].bus.am_v_o, 4'hF);
        check("lit reent gb_seq", 1, g_inst[1].bus.gb_seq_o, 0);

        // AM_PERIOD=4, GB_PERIOD=8: drop tx_en at k10.
        tx_en[2] = 1'b1;
        tick();
        repeat (10) tick();
        check("lit k10 ready", 2, g_inst[2].bus.ready_o, 1);
        check("lit k10 am_cnt", 2, g_inst[2].bus.am_cnt_o, 3);
        tx_en[2] = 1'b0;
        tick();
        check("lit drop ready", 2, g_inst[2].bus.ready_o, 0);
        check("lit drop am_v", 2, g_inst[2].bus.am_v_o, 0);
        check("lit drop stall", 2, g_inst[2].bus.gb_stall_o, 0);
        check("lit drop am_cnt", 2, g_inst[2].bus.am_cnt_o, 0);
        tx_en[2] = 1'b1;
        tick();
        check("lit reen am_v", 2, g_inst[2].bus.am_v_o, 4'hF);
        check("lit reen gb_seq", 2, g_inst[2].bus.gb_seq_o, 0);

        // Random enable/reset traffic on the small instances while the default
        // instance runs long enough for two full AM intervals.
        for (int c = 0; c < 36000; c++) begin
            for (int i = 1; i < 3; i++) begin
                if ($urandom_range(39) == 0) tx_en[i] = ~tx_en[i];
                nrst[i] = ($urandom_range(199) != 0);
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
